proc_arbiter: RTL and testbench

Round-robin arbiter that shares one capture/operate datapath and its sequencing controller between NREQ requesters. It accepts a request with operands B and C from one requester at a time, drives the operands and a one-cycle start pulse into the datapath, waits for the datapath's valid, and returns the result with a one-cycle acknowledge to the granted requester. It sits between the requester ports and the existing datapath/controller pair.

---
 rtl/proc_arb_pkg.sv | 14 +
 rtl/proc_arbiter_rr_pick.sv | 31 +++
 rtl/proc_arbiter.sv | 159 +++++++++++++++
 tb/tb_proc_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_arb_pkg.sv
// Shared types and defaults for the round-robin processing arbiter.
package proc_arb_pkg;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

endpackage

// File: rtl/proc_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or above ptr,
// wrapping modulo NREQ.
module rr_pick
    import proc_arb_pkg::*;
#(
    parameter  int unsigned NREQ = DEF_NREQ,
    localparam int unsigned PTRW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [PTRW-1:0] gnt_idx,
    output logic            any
);

    int unsigned idx;

    // Scan from ptr upward; the first hit wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = PTRW'(idx);
            end
        end
    end

endmodule

// File: rtl/proc_arbiter.sv
// Round-robin arbiter sharing one capture/operate datapath among NREQ
// requesters. Optional WAIT timeout is enabled by defining PROC_ARB_TIMEOUT_EN.
module proc_arbiter
    import proc_arb_pkg::*;
#(
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*WIDTH-1:0] req_c,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      result,
    output logic                  err,
    output logic                  dp_start,
    output logic [WIDTH-1:0]      dp_b,
    output logic [WIDTH-1:0]      dp_c,
    input  logic [WIDTH-1:0]      dp_result,
    input  logic                  dp_valid,
    output logic                  busy
);

    localparam int unsigned PTRW = $clog2(NREQ);

    arb_state_t      state_q, state_d;
    logic [PTRW-1:0] ptr_q, grant_q, pick_idx;
    logic            pick_any;
    logic [WIDTH-1:0] pick_b, pick_c;
    logic [WIDTH-1:0] result_q, dp_b_q, dp_c_q;
    logic            expire;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Select the operand slices belonging to the picked requester.
    always_comb begin
        pick_b = '0;
        pick_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == PTRW'(i)) begin
                pick_b = req_b[i*WIDTH +: WIDTH];
                pick_c = req_c[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef PROC_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    // Expiry fires on the TIMEOUT-th WAIT cycle.
    assign expire = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT - 1));
    assign err    = err_q;

    // WAIT cycle counter, cleared while issuing so it starts at zero in WAIT.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            cnt_q <= '0;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Error flag: a real dp_valid always takes priority over expiry.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == WAIT) begin
            if (dp_valid) begin
                err_q <= 1'b0;
            end else if (expire) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (dp_valid || expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, operand, result and pointer registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            grant_q  <= '0;
            dp_b_q   <= '0;
            dp_c_q   <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        dp_b_q  <= pick_b;
                        dp_c_q  <= pick_c;
                    end
                end
                WAIT: begin
                    if (dp_valid) begin
                        result_q <= dp_result;
                    end else if (expire) begin
                        result_q <= '0;
                    end
                end
                RESP: begin
                    ptr_q <= (grant_q == PTRW'(NREQ - 1)) ? '0 : grant_q + PTRW'(1);
                end
                default: ;
            endcase
        end
    end

    // One-hot acknowledge decoded from the state register.
    always_comb begin
        ack = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            ack[i] = (state_q == RESP) && (grant_q == PTRW'(i));
        end
    end

    assign dp_start = (state_q == ISSUE);
    assign busy     = (state_q != IDLE);
    assign dp_b     = dp_b_q;
    assign dp_c     = dp_c_q;
    assign result   = result_q;

endmodule

// File: tb/tb_proc_arbiter.sv
// Directed self-checking bench for proc_arbiter; datapath is a 4-cycle
// start-to-valid controller model with an adding ALU.
module tb_proc_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    logic                  clock = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_b, req_c;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      result, dp_b, dp_c, dp_result;
    logic                  err, dp_start, dp_valid, busy;

    logic [3:0] dp_sh = '0;
    logic       dp_en;
    logic       dp_force;

    int n_assert = 0;
    int n_fail   = 0;

    int         cyc;
    logic [3:0] a;
    logic [7:0] r;
    logic       e;

    logic [3:0] t6_ack [0:4];
    logic [7:0] t6_res [0:4];
    int         t6_cyc [0:4];

    proc_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(15)) dut (
        .clock     (clock),
        .rst       (rst),
        .req       (req),
        .req_b     (req_b),
        .req_c     (req_c),
        .ack       (ack),
        .result    (result),
        .err       (err),
        .dp_start  (dp_start),
        .dp_b      (dp_b),
        .dp_c      (dp_c),
        .dp_result (dp_result),
        .dp_valid  (dp_valid),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Controller model: dp_valid four cycles after the start pulse.
    always @(posedge clock) dp_sh <= {dp_sh[2:0], dp_start};
    assign dp_valid  = (dp_sh[3] & dp_en) | dp_force;
    assign dp_result = dp_b + dp_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_ack(output int c, output logic [3:0] ak, output logic [7:0] rs, output logic er);
        c  = -1;
        ak = '0;
        rs = '0;
        er = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (ack != '0) begin
                c  = k;
                ak = ack;
                rs = result;
                er = err;
                break;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_b    = {8'h01, 8'h55, 8'hF0, 8'h12};
        req_c    = {8'hFF, 8'hAA, 8'h20, 8'h34};
        dp_en    = 1'b1;
        dp_force = 1'b0;
        t6_ack   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t6_res   = '{8'h46, 8'h10, 8'hFF, 8'h00, 8'h46};
        t6_cyc   = '{6, 7, 7, 7, 7};

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_result", result, 8'h00);
        chk("rst_err", err, 1'b0);
        chk("rst_start", dp_start, 1'b0);
        chk("rst_dp_b", dp_b, 8'h00);
        chk("rst_dp_c", dp_c, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clock);

        // Single requester 0, cycle-by-cycle timing
        req = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            chk("t1_start", dp_start, (k == 1));
            chk("t1_busy", busy, 1'b1);
            chk("t1_dp_b", dp_b, 8'h12);
            chk("t1_dp_c", dp_c, 8'h34);
            chk("t1_ack", ack, (k == 6) ? 4'b0001 : 4'b0000);
        end
        chk("t1_result", result, 8'h46);
        chk("t1_err", err, 1'b0);
        req = '0;
        @(negedge clock);
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_idle_ack", ack, 4'b0000);

        // Requester 1 from ptr=1 -> ptr becomes 2
        req = 4'b0010;
        wait_ack(cyc, a, r, e);
        chk("t2_lat", cyc, 6);
        chk("t2_ack", a, 4'b0010);
        chk("t2_res", r, 8'h10);
        chk("t2_err", e, 1'b0);
        req = '0;
        @(negedge clock);

        // ptr=2, req=0011: wrap to 0 then 1
        req = 4'b0011;
        wait_ack(cyc, a, r, e);
        chk("t3_lat0", cyc, 6);
        chk("t3_ack0", a, 4'b0001);
        chk("t3_res0", r, 8'h46);
        wait_ack(cyc, a, r, e);
        chk("t3_lat1", cyc, 7);
        chk("t3_ack1", a, 4'b0010);
        chk("t3_res1", r, 8'h10);
        req = '0;
        @(negedge clock);

        // Requester 1 drops req during WAIT; ack still pulses once
        req = 4'b0010;
        repeat (3) @(negedge clock);
        chk("t4_busy", busy, 1'b1);
        req = '0;
        wait_ack(cyc, a, r, e);
        chk("t4_lat", cyc, 3);
        chk("t4_ack", a, 4'b0010);
        chk("t4_res", r, 8'h10);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            chk("t4_after_ack", ack, 4'b0000);
            chk("t4_after_busy", busy, 1'b0);
        end

        // Reset during WAIT aborts with no ack
        req = 4'b0100;
        repeat (3) @(negedge clock);
        chk("t5_busy", busy, 1'b1);
        chk("t5_dp_b", dp_b, 8'h55);
        chk("t5_dp_c", dp_c, 8'hAA);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_ack", ack, 4'b0000);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_start", dp_start, 1'b0);
        chk("t5_rst_dp_b", dp_b, 8'h00);
        chk("t5_rst_dp_c", dp_c, 8'h00);
        chk("t5_rst_result", result, 8'h00);
        chk("t5_rst_err", err, 1'b0);
        req = '0;
        @(negedge clock);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            chk("t5_no_ack", ack, 4'b0000);
            chk("t5_idle", busy, 1'b0);
        end

        // All requesting from ptr=0: 0,1,2,3,0 spaced 7 cycles
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(cyc, a, r, e);
            chk("t6_lat", cyc, t6_cyc[i]);
            chk("t6_ack", a, t6_ack[i]);
            chk("t6_res", r, t6_res[i]);
            chk("t6_err", e, 1'b0);
        end
        req = '0;
        @(negedge clock);

`ifdef PROC_ARB_TIMEOUT_EN
        // Datapath never valid: abort after 15 WAIT cycles
        dp_en = 1'b0;
        req   = 4'b0001;
        wait_ack(cyc, a, r, e);
        chk("to_lat", cyc, 17);
        chk("to_ack", a, 4'b0001);
        chk("to_res", r, 8'h00);
        chk("to_err", e, 1'b1);
        req = '0;
        @(negedge clock);

        // dp_valid on the expiry cycle wins
        req = 4'b0001;
        repeat (16) @(negedge clock);
        chk("to_edge_busy", busy, 1'b1);
        dp_force = 1'b1;
        @(negedge clock);
        dp_force = 1'b0;
        chk("to_edge_ack", ack, 4'b0001);
        chk("to_edge_res", result, 8'h46);
        chk("to_edge_err", err, 1'b0);
        req = '0;
        @(negedge clock);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
